// File: rtl/edge_window_scheduler.sv
// edge_window_scheduler: walks an IMG_W x IMG_H image in 3x3 output tiles.
// Each tile fetches a 5x5 pixel window, hands it to a gradient core, then
// writes the nine core sums back to the centre 3x3 of the tile.
//
// Ports:
//   clk, n_rst          clock (rising edge), async reset (active-high)
//   start               frame start request (honoured in IDLE only)
//   busy, done          frame in progress / one-cycle completion pulse
//   rd_en, rd_addr      pixel read strobe and address
//   rd_data             pixel data, valid the cycle after rd_en
//   win_data            5x5 window, m1 in [7:0] .. m25 in [199:192]
//   gradient_start      one-cycle start to the core
//   gradient_ready      core results valid
//   result              core sums, sum_1 in [7:0] .. sum_9 in [71:64]
//   wr_en, wr_addr,
//   wr_data, wr_ready   result write handshake
//   err                 sticky timeout flag (0 unless timeout enabled)
//
// Optional feature macro: EDGE_SCHED_TIMEOUT_EN enables a 16-cycle WAIT
// timeout that aborts the frame and sets err.
module edge_window_scheduler #(
    parameter int unsigned IMG_W  = 11,
    parameter int unsigned IMG_H  = 11,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [199:0]      win_data,
    output logic              gradient_start,
    input  logic              gradient_ready,
    input  logic [71:0]       result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              wr_ready,
    output logic              err
);

    localparam int unsigned CRD_W  = 16;
    localparam int unsigned TX_LIM = IMG_W - 2;
    localparam int unsigned TY_LIM = IMG_H - 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        FLUSH = 3'd2,
        START = 3'd3,
        WAIT  = 3'd4,
        WRITE = 3'd5,
        NEXT  = 3'd6,
        DONE  = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [CRD_W-1:0]  tx_q, tx_d, ty_q, ty_d;
    logic [2:0]        r_q, r_d, c_q, c_d;
    logic [4:0]        idx_q, idx_d;
    logic              cap_en_q;
    logic [4:0]        cap_slot_q;
    logic [24:0][7:0]  win_q;
    logic [8:0][7:0]   res_q, res_d;
    logic [3:0]        k_q, k_d;
    logic [1:0]        wr_r_q, wr_r_d, wr_c_q, wr_c_d;
    logic              tile_last_col, tile_last_row;

    logic              busy_q, busy_d, done_q, done_d;
    logic              rd_en_q, rd_en_d, gs_q, gs_d, wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;

`ifdef EDGE_SCHED_TIMEOUT_EN
    logic [4:0]        to_q, to_d;
    logic              err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy           = busy_q;
    assign done           = done_q;
    assign rd_en          = rd_en_q;
    assign rd_addr        = rd_addr_q;
    assign gradient_start = gs_q;
    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign win_data       = win_q;

    // Next-state logic; outputs are derived from the next state so that the
    // registered outputs line up with the state they belong to.
    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        ty_d     = ty_q;
        r_d      = r_q;
        c_d      = c_q;
        idx_d    = idx_q;
        res_d    = res_q;
        k_d      = k_q;
        wr_r_d   = wr_r_q;
        wr_c_d   = wr_c_q;
`ifdef EDGE_SCHED_TIMEOUT_EN
        to_d     = to_q;
        err_d    = err_q;
`endif
        tile_last_col = (32'(tx_q) + 32'd3) >= 32'(TX_LIM);
        tile_last_row = (32'(ty_q) + 32'd3) >= 32'(TY_LIM);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    tx_d    = '0;
                    ty_d    = '0;
                    r_d     = '0;
                    c_d     = '0;
                    idx_d   = '0;
                end
            end
            FETCH: begin
                if (idx_q == 5'd24) begin
                    state_d = FLUSH;
                end else begin
                    idx_d = idx_q + 5'd1;
                    if (c_q == 3'd4) begin
                        c_d = '0;
                        r_d = r_q + 3'd1;
                    end else begin
                        c_d = c_q + 3'd1;
                    end
                end
            end
            FLUSH: state_d = START;
            START: begin
                state_d = WAIT;
`ifdef EDGE_SCHED_TIMEOUT_EN
                to_d    = '0;
`endif
            end
            WAIT: begin
                if (gradient_ready) begin
                    res_d   = result;
                    state_d = WRITE;
                    k_d     = '0;
                    wr_r_d  = '0;
                    wr_c_d  = '0;
                end
`ifdef EDGE_SCHED_TIMEOUT_EN
                else if (to_q == 5'd15) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    to_d = to_q + 5'd1;
                end
`endif
            end
            WRITE: begin
                // Advance only on an accepted write; otherwise everything holds.
                if (wr_en_q && wr_ready) begin
                    if (k_q == 4'd8) begin
                        state_d = NEXT;
                    end else begin
                        k_d = k_q + 4'd1;
                        if (wr_c_q == 2'd2) begin
                            wr_c_d = '0;
                            wr_r_d = wr_r_q + 2'd1;
                        end else begin
                            wr_c_d = wr_c_q + 2'd1;
                        end
                    end
                end
            end
            NEXT: begin
                r_d   = '0;
                c_d   = '0;
                idx_d = '0;
                if (!tile_last_col) begin
                    tx_d    = tx_q + CRD_W'(3);
                    state_d = FETCH;
                end else begin
                    tx_d    = '0;
                    ty_d    = ty_q + CRD_W'(3);
                    state_d = tile_last_row ? DONE : FETCH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        gs_d      = (state_d == START);
        rd_en_d   = (state_d == FETCH);
        wr_en_d   = (state_d == WRITE);
        rd_addr_d = rd_en_d
            ? ADDR_W'((32'(ty_d) + 32'(r_d)) * 32'(IMG_W) + 32'(tx_d) + 32'(c_d))
            : '0;
        wr_addr_d = wr_en_d
            ? ADDR_W'((32'(ty_d) + 32'd1 + 32'(wr_r_d)) * 32'(IMG_W)
                      + 32'(tx_d) + 32'd1 + 32'(wr_c_d))
            : '0;
        wr_data_d = wr_en_d ? res_d[k_d] : '0;
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_q    <= IDLE;
            tx_q       <= '0;
            ty_q       <= '0;
            r_q        <= '0;
            c_q        <= '0;
            idx_q      <= '0;
            cap_en_q   <= 1'b0;
            cap_slot_q <= '0;
            win_q      <= '0;
            res_q      <= '0;
            k_q        <= '0;
            wr_r_q     <= '0;
            wr_c_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            gs_q       <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
`ifdef EDGE_SCHED_TIMEOUT_EN
            to_q       <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            ty_q       <= ty_d;
            r_q        <= r_d;
            c_q        <= c_d;
            idx_q      <= idx_d;
            res_q      <= res_d;
            k_q        <= k_d;
            wr_r_q     <= wr_r_d;
            wr_c_q     <= wr_c_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            gs_q       <= gs_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            // Read data trails its strobe by one cycle, so the slot is delayed too.
            cap_en_q   <= rd_en_q;
            cap_slot_q <= idx_q;
            if (cap_en_q) begin
                win_q[cap_slot_q] <= rd_data;
            end
`ifdef EDGE_SCHED_TIMEOUT_EN
            to_q       <= to_d;
            err_q      <= err_d;
`endif
        end
    end

endmodule
